// File: rtl/sprite_pixel_fetch.sv
// Sprite RAM read engine: hit test and address generation from the scan position,
// realignment of the returned colour with the scan stream, colour-key transparency.
module sprite_pixel_fetch #(
    parameter int          SPRITE_W    = 50,
    parameter int          SPRITE_H    = 50,
    parameter int          NUM_FRAMES  = 2,
    parameter int          ANIM_PERIOD = 30,
    parameter logic [23:0] TRANS_KEY   = 24'hFF00FF,
    parameter int          BASE_ADDR   = 0,
    localparam int         FSW         = (NUM_FRAMES > 1) ? $clog2(NUM_FRAMES) : 1
) (
    input  logic            Clk,
    input  logic            Reset_n,
    input  logic            pix_valid_in,
    input  logic [9:0]      DrawX,
    input  logic [9:0]      DrawY,
    input  logic [9:0]      sprite_x,
    input  logic [9:0]      sprite_y,
    input  logic            sprite_alive,
    input  logic            anim_en,
    input  logic            frame_tick,
    output logic [18:0]     read_address,
    input  logic [23:0]     ram_data,
    output logic            pix_valid_out,
    output logic            sprite_on,
    output logic [23:0]     sprite_rgb,
    output logic [FSW-1:0]  frame_sel
);

    localparam int CNT_W       = (ANIM_PERIOD > 1) ? $clog2(ANIM_PERIOD) : 1;
    localparam int FRAME_WORDS = SPRITE_W * SPRITE_H;
    localparam int PIPE        = 2;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } anim_state_t;

    // ------------------------------------------------------------------
    // Stage 0: hit test on the live scan position
    // ------------------------------------------------------------------
    logic [10:0] dx;
    logic [10:0] dy;
    logic        hit;
    logic [18:0] addr_calc;

    // Zero-extended subtraction: bit 10 set means the scan is left of / above the sprite.
    assign dx = {1'b0, DrawX} - {1'b0, sprite_x};
    assign dy = {1'b0, DrawY} - {1'b0, sprite_y};

    assign hit = pix_valid_in & sprite_alive
               & ~dx[10] & (dx < 11'(SPRITE_W))
               & ~dy[10] & (dy < 11'(SPRITE_H));

    logic [FSW-1:0] frame_sel_q;
    logic [FSW-1:0] frame_sel_d;

    assign addr_calc = 19'(BASE_ADDR)
                     + 19'(frame_sel_q) * 19'(FRAME_WORDS)
                     + 19'(dy[9:0]) * 19'(SPRITE_W)
                     + 19'(dx[9:0]);

    // ------------------------------------------------------------------
    // Stage 1: address register; misses keep the previous address
    // ------------------------------------------------------------------
    logic [18:0] read_address_q;
    logic [18:0] read_address_d;

    always_comb begin
        read_address_d = read_address_q;
        if (hit) begin
            read_address_d = addr_calc;
        end
    end

    // ------------------------------------------------------------------
    // Valid/hit delay line covering the address stage and the RAM stage
    // ------------------------------------------------------------------
    logic [PIPE-1:0] v_q;
    logic [PIPE-1:0] v_d;
    logic [PIPE-1:0] h_q;
    logic [PIPE-1:0] h_d;

    assign v_d[0] = pix_valid_in;
    assign h_d[0] = hit;

    genvar gi;
    generate
        for (gi = 1; gi < PIPE; gi++) begin : g_pipe
            assign v_d[gi] = v_q[gi-1];
            assign h_d[gi] = h_q[gi-1];
        end
    endgenerate

    // ------------------------------------------------------------------
    // Stage 3: colour-key and output register
    // ------------------------------------------------------------------
    logic        pix_valid_out_q;
    logic        pix_valid_out_d;
    logic        sprite_on_q;
    logic        sprite_on_d;
    logic [23:0] sprite_rgb_q;
    logic [23:0] sprite_rgb_d;

    always_comb begin
        pix_valid_out_d = v_q[PIPE-1];
        sprite_on_d     = h_q[PIPE-1] & (ram_data != TRANS_KEY);
        sprite_rgb_d    = sprite_on_d ? ram_data : 24'd0;
    end

    // ------------------------------------------------------------------
    // Animation: tick counter and frame register
    // ------------------------------------------------------------------
    anim_state_t      state_q;
    anim_state_t      state_d;
    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;
    logic             count_tick;

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        frame_sel_d = frame_sel_q;
        count_tick  = 1'b0;

        // The enable acts in the same cycle it changes, so the registered state only
        // records the mode; a tick arriving on the resume cycle is still counted.
        case (state_q)
            IDLE: begin
                if (anim_en) begin
                    state_d    = RUN;
                    count_tick = frame_tick;
                end
            end
            RUN: begin
                if (!anim_en) begin
                    state_d = IDLE;
                end else begin
                    count_tick = frame_tick;
                end
            end
            default: state_d = IDLE;
        endcase

        if (count_tick) begin
            if (cnt_q == CNT_W'(ANIM_PERIOD - 1)) begin
                cnt_d = '0;
                if (frame_sel_q == FSW'(NUM_FRAMES - 1)) begin
                    frame_sel_d = '0;
                end else begin
                    frame_sel_d = frame_sel_q + FSW'(1);
                end
            end else begin
                cnt_d = cnt_q + CNT_W'(1);
            end
        end
    end

    // ------------------------------------------------------------------
    // State registers
    // ------------------------------------------------------------------
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            read_address_q  <= '0;
            v_q             <= '0;
            h_q             <= '0;
            pix_valid_out_q <= 1'b0;
            sprite_on_q     <= 1'b0;
            sprite_rgb_q    <= '0;
            state_q         <= IDLE;
            cnt_q           <= '0;
            frame_sel_q     <= '0;
        end else begin
            read_address_q  <= read_address_d;
            v_q             <= v_d;
            h_q             <= h_d;
            pix_valid_out_q <= pix_valid_out_d;
            sprite_on_q     <= sprite_on_d;
            sprite_rgb_q    <= sprite_rgb_d;
            state_q         <= state_d;
            cnt_q           <= cnt_d;
            frame_sel_q     <= frame_sel_d;
        end
    end

    assign read_address  = read_address_q;
    assign pix_valid_out = pix_valid_out_q;
    assign sprite_on     = sprite_on_q;
    assign sprite_rgb    = sprite_rgb_q;
    assign frame_sel     = frame_sel_q;

endmodule

// File: tb/tb_sprite_pixel_fetch.sv
// Bench for sprite_pixel_fetch: behavioural sprite RAM, vector table plus scoreboard
// queues for address and output, directed reset and animation sequences.
module tb_sprite_pixel_fetch;

    localparam int SW = 50;
    localparam int SH = 50;

    logic        Clk;
    logic        Reset_n;
    logic        pix_valid_in;
    logic [9:0]  DrawX, DrawY, sprite_x, sprite_y;
    logic        sprite_alive, anim_en, frame_tick;
    logic [18:0] read_address;
    logic [23:0] ram_data;
    logic        pix_valid_out, sprite_on;
    logic [23:0] sprite_rgb;
    logic [0:0]  frame_sel;

    sprite_pixel_fetch dut (
        .Clk          (Clk),
        .Reset_n      (Reset_n),
        .pix_valid_in (pix_valid_in),
        .DrawX        (DrawX),
        .DrawY        (DrawY),
        .sprite_x     (sprite_x),
        .sprite_y     (sprite_y),
        .sprite_alive (sprite_alive),
        .anim_en      (anim_en),
        .frame_tick   (frame_tick),
        .read_address (read_address),
        .ram_data     (ram_data),
        .pix_valid_out(pix_valid_out),
        .sprite_on    (sprite_on),
        .sprite_rgb   (sprite_rgb),
        .frame_sel    (frame_sel)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    logic [23:0] mem [0:8191];
    always @(posedge Clk) ram_data <= mem[read_address[12:0]];

    typedef struct {
        int          due;
        logic        hit;
        logic        on;
        logic [18:0] addr;
        logic [23:0] rgb;
    } exp_t;

    exp_t addr_q[$];
    exp_t out_q[$];

    int n_checks = 0;
    int n_pass   = 0;
    int cyc      = 0;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h required %h (cyc %0d)", name, got, exp, cyc);
    endtask

    // Scoreboard monitor, sampled 1 time unit after each rising edge.
    always @(posedge Clk) begin
        exp_t e;
        #1;
        cyc++;
        if (Reset_n) begin
            while (addr_q.size() > 0 && addr_q[0].due <= cyc) begin
                e = addr_q.pop_front();
                check("read_address", 32'(read_address), 32'(e.addr));
            end
            if (pix_valid_out) begin
                if (out_q.size() == 0) begin
                    check("unexpected_valid", 32'(pix_valid_out), 32'd0);
                end else begin
                    e = out_q.pop_front();
                    $display("pix cyc=%0d due=%0d on=%0b rgb=%h", cyc, e.due, sprite_on, sprite_rgb);
                    check("latency", cyc, e.due);
                    check("sprite_on", 32'(sprite_on), 32'(e.on));
                    check("sprite_rgb", 32'(sprite_rgb), 32'(e.rgb));
                end
            end else if (out_q.size() > 0 && out_q[0].due <= cyc) begin
                e = out_q.pop_front();
                check("missing_valid", 32'(pix_valid_out), 32'd1);
            end
        end
    end

    task automatic drive_pix(input logic [9:0] x, input logic [9:0] y,
                             input logic [9:0] sx, input logic [9:0] sy, input logic alive,
                             input logic eh, input logic eo,
                             input logic [18:0] ea, input logic [23:0] er);
        exp_t e;
        @(negedge Clk);
        pix_valid_in = 1'b1;
        DrawX = x; DrawY = y; sprite_x = sx; sprite_y = sy; sprite_alive = alive;
        e.due = cyc + 3; e.hit = eh; e.on = eo; e.addr = ea; e.rgb = er;
        out_q.push_back(e);
        if (eh) begin
            e.due = cyc + 1;
            addr_q.push_back(e);
        end
    endtask

    task automatic idle();
        @(negedge Clk);
        pix_valid_in = 1'b0;
    endtask

    task automatic drain();
        int n;
        idle();
        n = 0;
        while ((out_q.size() > 0 || addr_q.size() > 0) && n < 12) begin
            @(negedge Clk);
            n++;
        end
        if (out_q.size() > 0 || addr_q.size() > 0) begin
            check("drain_timeout", 32'(out_q.size() + addr_q.size()), 32'd0);
            out_q.delete();
            addr_q.delete();
        end
    endtask

    task automatic do_reset();
        @(negedge Clk);
        Reset_n = 1'b0;
        anim_en = 1'b0;
        frame_tick = 1'b0;
        out_q.delete();
        addr_q.delete();
        #1;
        check("rst_read_address", 32'(read_address), 32'd0);
        check("rst_pix_valid_out", 32'(pix_valid_out), 32'd0);
        check("rst_sprite_on", 32'(sprite_on), 32'd0);
        check("rst_sprite_rgb", 32'(sprite_rgb), 32'd0);
        check("rst_frame_sel", 32'(frame_sel), 32'd0);
        repeat (2) @(negedge Clk);
        Reset_n = 1'b1;
    endtask

    task automatic tick(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge Clk);
            frame_tick = 1'b1;
            @(negedge Clk);
            frame_tick = 1'b0;
        end
    endtask

    function automatic void model(input int x, input int y, input int sx, input int sy,
                                  input logic alive, input int f,
                                  output logic h, output logic on,
                                  output logic [18:0] a, output logic [23:0] rgb);
        int dx, dy;
        dx = x - sx;
        dy = y - sy;
        h = alive && dx >= 0 && dx < SW && dy >= 0 && dy < SH;
        a = h ? 19'(f * SW * SH + dy * SW + dx) : 19'd0;
        rgb = h ? mem[a[12:0]] : 24'd0;
        on = h && (rgb != 24'hFF00FF);
        if (!on) rgb = 24'd0;
    endfunction

    typedef struct {
        logic [9:0]  x, y, sx, sy;
        logic        alive;
        logic        hit;
        logic        on;
        logic [18:0] addr;
        logic [23:0] rgb;
    } vec_t;

    vec_t vecs [11];

    initial begin
        logic        mh, mo;
        logic [18:0] ma;
        logic [23:0] mr;
        int          sx, sy, x, y, f;
        logic        al;

        for (int i = 0; i < 8192; i++) mem[i] = {4'hA, 20'(i)};
        mem[160]  = 24'h123456;
        mem[55]   = 24'hFF00FF;
        mem[2660] = 24'hABCDEF;

        vecs[0]  = '{10'd110, 10'd203, 10'd100, 10'd200, 1'b1, 1'b1, 1'b1, 19'd160,  24'h123456};
        vecs[1]  = '{10'd99,  10'd200, 10'd100, 10'd200, 1'b1, 1'b0, 1'b0, 19'd0,    24'h000000};
        vecs[2]  = '{10'd100, 10'd200, 10'd100, 10'd200, 1'b1, 1'b1, 1'b1, 19'd0,    24'hA00000};
        vecs[3]  = '{10'd149, 10'd200, 10'd100, 10'd200, 1'b1, 1'b1, 1'b1, 19'd49,   24'hA00031};
        vecs[4]  = '{10'd150, 10'd200, 10'd100, 10'd200, 1'b1, 1'b0, 1'b0, 19'd0,    24'h000000};
        vecs[5]  = '{10'd105, 10'd201, 10'd100, 10'd200, 1'b1, 1'b1, 1'b0, 19'd55,   24'h000000};
        vecs[6]  = '{10'd110, 10'd203, 10'd100, 10'd200, 1'b0, 1'b0, 1'b0, 19'd0,    24'h000000};
        vecs[7]  = '{10'd100, 10'd249, 10'd100, 10'd200, 1'b1, 1'b1, 1'b1, 19'd2450, 24'hA00992};
        vecs[8]  = '{10'd100, 10'd250, 10'd100, 10'd200, 1'b1, 1'b0, 1'b0, 19'd0,    24'h000000};
        vecs[9]  = '{10'd5,   10'd12,  10'd300, 10'd10,  1'b1, 1'b0, 1'b0, 19'd0,    24'h000000};
        vecs[10] = '{10'd49,  10'd49,  10'd0,   10'd0,   1'b1, 1'b1, 1'b1, 19'd2499, 24'hA009C3};

        Reset_n = 1'b1;
        pix_valid_in = 1'b0;
        DrawX = '0; DrawY = '0; sprite_x = '0; sprite_y = '0;
        sprite_alive = 1'b0; anim_en = 1'b0; frame_tick = 1'b0;
        #2;
        do_reset();

        // Vector table, applied back to back.
        for (int i = 0; i < 11; i++) begin
            drive_pix(vecs[i].x, vecs[i].y, vecs[i].sx, vecs[i].sy, vecs[i].alive,
                      vecs[i].hit, vecs[i].on, vecs[i].addr, vecs[i].rgb);
        end
        drain();

        // Reset with pixels in flight: nothing stale may emerge afterwards.
        drive_pix(10'd110, 10'd203, 10'd100, 10'd200, 1'b1, 1'b1, 1'b1, 19'd160, 24'h123456);
        drive_pix(10'd100, 10'd200, 10'd100, 10'd200, 1'b1, 1'b1, 1'b1, 19'd0,   24'hA00000);
        do_reset();
        pix_valid_in = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(negedge Clk);
            check("post_reset_quiet", 32'(pix_valid_out), 32'd0);
        end
        drive_pix(10'd149, 10'd200, 10'd100, 10'd200, 1'b1, 1'b1, 1'b1, 19'd49, 24'hA00031);
        drain();

        // Animation: toggle on the 30th tick, wrap after 60.
        @(negedge Clk);
        anim_en = 1'b1;
        tick(29);
        check("frame_after_29", 32'(frame_sel), 32'd0);
        tick(1);
        check("frame_after_30", 32'(frame_sel), 32'd1);
        drive_pix(10'd110, 10'd203, 10'd100, 10'd200, 1'b1, 1'b1, 1'b1, 19'd2660, 24'hABCDEF);
        drain();
        tick(29);
        check("frame_after_59", 32'(frame_sel), 32'd1);
        tick(1);
        check("frame_after_60", 32'(frame_sel), 32'd0);

        // Pause mid-period, then resume from the held count.
        tick(10);
        @(negedge Clk);
        anim_en = 1'b0;
        tick(50);
        check("frame_paused", 32'(frame_sel), 32'd0);
        @(negedge Clk);
        anim_en = 1'b1;
        tick(19);
        check("frame_resume_19", 32'(frame_sel), 32'd0);
        tick(1);
        check("frame_resume_20", 32'(frame_sel), 32'd1);

        // Back-to-back burst with sprite position changing every pixel, frame 1.
        f = 1;
        for (int i = 0; i < 40; i++) begin
            sx = 200 + $urandom_range(0, 20);
            sy = 100 + $urandom_range(0, 20);
            x  = sx - 5 + $urandom_range(0, 60);
            y  = sy - 3 + $urandom_range(0, 56);
            al = ($urandom_range(0, 7) != 0);
            model(x, y, sx, sy, al, f, mh, mo, ma, mr);
            drive_pix(10'(x), 10'(y), 10'(sx), 10'(sy), al, mh, mo, ma, mr);
        end
        drain();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish, got timeout required completion");
        $fatal(1, "watchdog");
    end

endmodule
